// File: rtl/fifo_param_sync.sv
// fifo_param_sync: parametrised single-clock FIFO with occupancy, thresholds, flush and sticky errors
module fifo_param_sync #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_fifo,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic r_dov, r_ovf, r_unf;
  logic w_rd, w_wr, w_rd_go, w_wr_go, w_ovf, w_unf;
  logic [PW-1:0] w_wr_inc, w_rd_inc;
  assign fifo_full = r_count == CW'(DEPTH);
  assign fifo_empty = r_count == '0;
  assign almost_full = r_count >= CW'(AF_THRESH);
  assign almost_empty = r_count <= CW'(AE_THRESH);
  assign count = r_count;
  assign data_out = r_data_out;
  assign data_out_valid = r_dov;
  assign overflow_err = r_ovf;
  assign underflow_err = r_unf;
  assign w_rd = pop_fifo & ~fifo_empty;
  assign w_wr = data_in_valid & (~fifo_full | w_rd);
  assign w_rd_go = w_rd & ~flush;
  assign w_wr_go = w_wr & ~flush;
  assign w_ovf = data_in_valid & fifo_full & ~w_rd & ~flush;
  assign w_unf = pop_fifo & fifo_empty & ~flush;
  assign w_wr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  always_ff @(posedge clk)
    if (w_wr_go) r_mem[r_wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_data_out <= '0;
      r_dov <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_dov <= w_rd_go;
      if (w_rd_go) r_data_out <= r_mem[r_rd_ptr];
      r_wr_ptr <= flush ? '0 : w_wr_go ? w_wr_inc : r_wr_ptr;
      r_rd_ptr <= flush ? '0 : w_rd_go ? w_rd_inc : r_rd_ptr;
      r_count <= flush ? '0 :
                 (w_wr_go & ~w_rd_go) ? r_count + CW'(1) :
                 (w_rd_go & ~w_wr_go) ? r_count - CW'(1) : r_count;
      r_ovf <= w_ovf | (r_ovf & ~clear_err);
      r_unf <= w_unf | (r_unf & ~clear_err);
    end
endmodule

// File: tb/tb_fifo_param_sync.sv
// tb_fifo_param_sync: vector table plus scoreboarded corner-case sequences for fifo_param_sync
module tb_fifo_param_sync;
  localparam logic [63:0] A = 64'h2222_2222_2222_2222;
  logic clk = 1'b0, reset_n = 1'b0;
  logic data_in_valid = 1'b0, pop_fifo = 1'b0, flush = 1'b0, clear_err = 1'b0;
  logic [63:0] data_in = '0, data_out;
  logic data_out_valid, fifo_full, fifo_empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [63:0] model_q[$], sb_q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  logic [63:0] last;
  typedef struct {
    logic vld; logic [63:0] din; logic pop; logic fl; logic clr;
    int e_cnt; logic e_dov; logic [63:0] e_dout; logic e_ovf; logic e_unf;
    logic [3:0] e_flags;
  } vec_t;
  vec_t vt[13];
  always #5 clk = ~clk;
  fifo_param_sync #(.DATA_WIDTH(64), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in_valid(data_in_valid), .data_in(data_in),
    .pop_fifo(pop_fifo), .flush(flush), .clear_err(clear_err), .data_out(data_out),
    .data_out_valid(data_out_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [63:0] d, input logic p, input logic f, input logic c);
    logic rd, wr, n_ovf, n_unf;
    data_in_valid = v; data_in = d; pop_fifo = p; flush = f; clear_err = c;
    rd = p && model_q.size() > 0 && !f;
    wr = v && (model_q.size() < 4 || (p && model_q.size() > 0)) && !f;
    n_ovf = v && model_q.size() == 4 && !(p && model_q.size() > 0) && !f;
    n_unf = p && model_q.size() == 0 && !f;
    if (f) model_q.delete();
    if (rd) sb_q.push_back(model_q.pop_front());
    if (wr) model_q.push_back(d);
    m_ovf = n_ovf | (m_ovf & ~c);
    m_unf = n_unf | (m_unf & ~c);
    @(posedge clk); #1;
    data_in_valid = 1'b0; pop_fifo = 1'b0; flush = 1'b0; clear_err = 1'b0;
    if (data_out_valid) begin
      if (sb_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else chk("sb_data", data_out, sb_q.pop_front());
    end else if (sb_q.size() != 0) begin
      chk("missing_valid", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    chk("model_count", 64'(count), 64'(model_q.size()));
    chk("model_ovf", 64'(overflow_err), 64'(m_ovf));
    chk("model_unf", 64'(underflow_err), 64'(m_unf));
  endtask
  function automatic vec_t mk(logic v, logic [63:0] d, logic p, logic c, int n, logic dv,
                              logic [63:0] dout, logic o, logic u, logic [3:0] fl);
    vec_t r;
    r.vld = v; r.din = d; r.pop = p; r.fl = 1'b0; r.clr = c; r.e_cnt = n; r.e_dov = dv;
    r.e_dout = dout; r.e_ovf = o; r.e_unf = u; r.e_flags = fl;
    return r;
  endfunction
  initial begin
    vt[0]  = mk(0, 0,   1, 0, 0, 0, 0,     0, 1, 4'b0101);
    vt[1]  = mk(0, 0,   0, 1, 0, 0, 0,     0, 0, 4'b0101);
    vt[2]  = mk(1, A,   0, 0, 1, 0, 0,     0, 0, 4'b0001);
    vt[3]  = mk(1, A*2, 0, 0, 2, 0, 0,     0, 0, 4'b0000);
    vt[4]  = mk(1, A*3, 0, 0, 3, 0, 0,     0, 0, 4'b0010);
    vt[5]  = mk(1, A*4, 0, 0, 4, 0, 0,     0, 0, 4'b1010);
    vt[6]  = mk(1, A*5, 0, 0, 4, 0, 0,     1, 0, 4'b1010);
    vt[7]  = mk(0, 0,   1, 0, 3, 1, A,     1, 0, 4'b0010);
    vt[8]  = mk(0, 0,   1, 0, 2, 1, A*2,   1, 0, 4'b0000);
    vt[9]  = mk(0, 0,   1, 0, 1, 1, A*3,   1, 0, 4'b0001);
    vt[10] = mk(0, 0,   1, 0, 0, 1, A*4,   1, 0, 4'b0101);
    vt[11] = mk(0, 0,   0, 0, 0, 0, A*4,   1, 0, 4'b0101);
    vt[12] = mk(0, 0,   0, 1, 0, 0, A*4,   0, 0, 4'b0101);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_flags", 64'({fifo_full, fifo_empty, almost_full, almost_empty}), 64'b0101);
    chk("rst_dout", data_out, 0);
    chk("rst_dov", 64'(data_out_valid), 0);
    chk("rst_errs", 64'({overflow_err, underflow_err}), 0);
    for (int i = 0; i < 13; i++) begin
      step(vt[i].vld, vt[i].din, vt[i].pop, vt[i].fl, vt[i].clr);
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("v%0d_dov", i), 64'(data_out_valid), 64'(vt[i].e_dov));
      chk($sformatf("v%0d_dout", i), data_out, vt[i].e_dout);
      chk($sformatf("v%0d_errs", i), 64'({overflow_err, underflow_err}), 64'({vt[i].e_ovf, vt[i].e_unf}));
      chk($sformatf("v%0d_flags", i), 64'({fifo_full, fifo_empty, almost_full, almost_empty}), 64'(vt[i].e_flags));
    end
    for (int i = 1; i <= 4; i++) step(1, 64'(i), 0, 0, 0);
    chk("full_before_rw", 64'(fifo_full), 1);
    step(1, 64'hAB, 1, 0, 0);
    chk("full_rw_count", 64'(count), 4);
    chk("full_rw_ovf", 64'(overflow_err), 0);
    chk("full_rw_dout", data_out, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("full_rw_last", data_out, 64'hAB);
    step(1, 64'h11, 1, 0, 0);
    chk("empty_rw_unf", 64'(underflow_err), 1);
    chk("empty_rw_count", 64'(count), 1);
    chk("empty_rw_dov", 64'(data_out_valid), 0);
    step(0, 0, 1, 0, 1);
    chk("empty_rw_pop", data_out, 64'h11);
    chk("empty_rw_clr", 64'(underflow_err), 0);
    for (int i = 0; i < 3; i++) step(1, 64'h30 + 64'(i), 0, 0, 0);
    step(1, 64'hDEAD, 1, 1, 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_empty", 64'(fifo_empty), 1);
    chk("flush_dov", 64'(data_out_valid), 0);
    chk("flush_errs", 64'({overflow_err, underflow_err}), 0);
    last = data_out;
    step(0, 0, 1, 0, 0);
    chk("flush_nothing_written", 64'(underflow_err), 1);
    chk("flush_dout_hold", data_out, last);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 64'h1000 + 64'(i), 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk($sformatf("wrap_%0d", i), data_out, 64'h1000 + 64'(i));
    end
    step(1, 64'h77, 0, 0, 0);
    step(1, 64'h88, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre_rst_dov", 64'(data_out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 0);
    chk("async_rst_flags", 64'({fifo_full, fifo_empty, almost_full, almost_empty}), 64'b0101);
    chk("async_rst_dout", data_out, 0);
    chk("async_rst_dov", 64'(data_out_valid), 0);
    model_q.delete(); sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    step(1, 64'h99, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("post_rst_data", data_out, 64'h99);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
